// File: rtl/spi_sync_fsm.sv
// spi_sync_fsm: turns the SPI receiver's load strobe into a fixed-width,
// sysclk-synchronous completion pulse (SPIDone).
//
// Optional feature macro: SPI_SYNC_INPUT_SYNC_EN
//   defined   -> SPILoad passes through a 2-flop synchronizer (reset to 0)
//                before the FSM; input-to-state latency grows by 2 cycles.
//   undefined -> SPILoad is sampled directly and must already be
//                synchronous to sysclk.
//
// CLKDiv is the pulse length minus one, in sysclk cycles (0 .. 2^32-2).
module spi_sync_fsm #(
    parameter logic [31:0] CLKDiv = 32'd1000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic SPILoad,
    output logic SPIDone
);

    typedef enum logic [1:0] {
        WAITING   = 2'b00,
        PULSE_ON  = 2'b01,
        PULSE_OFF = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        load;

`ifdef SPI_SYNC_INPUT_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer on the load strobe; cleared by reset.
    always_ff @(posedge sysclk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], SPILoad};
    end

    assign load = sync_q[1];
`else
    assign load = SPILoad;
`endif

    // State and hold-off counter registers; reset wins over every transition.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= WAITING;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and counter logic. The counter only runs in PULSE_OFF and is
    // held at zero everywhere else, so each pulse starts from a clean count.
    // The unused encoding falls into the default arm and recovers to WAITING.
    always_comb begin
        state_d = WAITING;
        count_d = 32'd0;
        case (state_q)
            WAITING: begin
                state_d = load ? PULSE_ON : WAITING;
            end
            PULSE_ON: begin
                state_d = load ? PULSE_ON : PULSE_OFF;
            end
            PULSE_OFF: begin
                // count never exceeds CLKDiv <= 2^32-2, so +1 cannot wrap.
                if (count_q < CLKDiv) begin
                    state_d = PULSE_OFF;
                    count_d = count_q + 32'd1;
                end else begin
                    state_d = WAITING;
                    count_d = 32'd0;
                end
            end
            default: begin
                state_d = WAITING;
                count_d = 32'd0;
            end
        endcase
    end

    // Moore output: decoded from the registered state only.
    assign SPIDone = (state_q == PULSE_OFF);

endmodule

// File: tb/tb_spi_sync_fsm.sv
// Scoreboard bench for spi_sync_fsm: four instances with different CLKDiv
// share one stimulus stream; a pulse-scheduler model predicts SPIDone.
module tb_spi_sync_fsm;

    localparam int N = 4;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       SPILoad = 1'b0;
    logic [N-1:0] done;

    int vectors    = 0;
    int miscompares = 0;

    always #5 sysclk = ~sysclk;

    spi_sync_fsm #(.CLKDiv(32'd1000)) dut_1000 (.sysclk(sysclk), .reset(reset), .SPILoad(SPILoad), .SPIDone(done[0]));
    spi_sync_fsm #(.CLKDiv(32'd0))    dut_0    (.sysclk(sysclk), .reset(reset), .SPILoad(SPILoad), .SPIDone(done[1]));
    spi_sync_fsm #(.CLKDiv(32'd4))    dut_4    (.sysclk(sysclk), .reset(reset), .SPILoad(SPILoad), .SPIDone(done[2]));
    spi_sync_fsm #(.CLKDiv(32'd10))   dut_10   (.sysclk(sysclk), .reset(reset), .SPILoad(SPILoad), .SPIDone(done[3]));

    // Reference model: a pulse is "remaining cycles of SPIDone"; a load is
    // armed by a high strobe and fires (CLKDiv+1)-cycle pulse when it drops.
    int        div [N] = '{1000, 0, 4, 10};
    int        left[N];
    bit        armed[N];
    bit [1:0]  pipe;
    logic [N-1:0] exp_q[$];

    function automatic void model_edge(input bit rst, input bit ld_in);
        bit ld;
`ifdef SPI_SYNC_INPUT_SYNC_EN
        ld   = pipe[1];
        pipe = rst ? 2'b00 : {pipe[0], ld_in};
`else
        ld   = ld_in;
`endif
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                left[i]  = 0;
                armed[i] = 0;
            end else if (left[i] > 0) begin
                left[i]--;               // load ignored while pulsing
            end else if (armed[i]) begin
                if (!ld) begin
                    armed[i] = 0;
                    left[i]  = div[i] + 1;
                end
            end else if (ld) begin
                armed[i] = 1;
            end
        end
    endfunction

    // Apply one cycle of stimulus before the coming rising edge and queue the
    // SPIDone vector expected just after that edge.
    task automatic cyc(input bit rst, input bit ld);
        logic [N-1:0] e;
        @(negedge sysclk);
        reset   = rst;
        SPILoad = ld;
        model_edge(rst, ld);
        for (int i = 0; i < N; i++) e[i] = (left[i] > 0);
        exp_q.push_back(e);
    endtask

    task automatic run(input bit ld, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, ld);
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    initial begin
        logic [N-1:0] e;
        forever begin
            @(posedge sysclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    vectors++;
                    if (done[i] !== e[i]) begin
                        miscompares++;
                        $display("FAIL spidone[div=%0d] t=%0t got=%b want=%b", div[i], $time, done[i], e[i]);
                    end
                end
            end
        end
    end

    initial begin
        int gap, len;
        for (int i = 0; i < N; i++) begin left[i] = 0; armed[i] = 0; end
        pipe = 2'b00;

        // Reset for 2 cycles, then idle: everyone stays low.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        run(1'b0, 8);

        // Long load of 3 cycles, then the full 1001-cycle pulse of dut_1000.
        run(1'b1, 3);
        run(1'b0, 1010);

        // Single-cycle load.
        run(1'b1, 1);
        run(1'b0, 14);

        // Re-assert during dut_4's pulse: no second pulse.
        run(1'b1, 1);
        run(1'b0, 1);
        run(1'b1, 2);
        run(1'b0, 12);

        // Load still high when the pulse ends: back-to-back pulses.
        run(1'b1, 1);
        run(1'b0, 1);
        run(1'b1, 8);
        run(1'b0, 14);

        // Reset in the middle of a pulse, then a fresh load.
        run(1'b1, 1);
        run(1'b0, 3);
        cyc(1'b1, 1'b0);
        run(1'b0, 6);
        run(1'b1, 2);
        run(1'b0, 14);

        // Randomized strobes with occasional resets.
        for (int t = 0; t < 150; t++) begin
            len = $urandom_range(1, 6);
            gap = $urandom_range(0, 12);
            for (int k = 0; k < len; k++) cyc(($urandom_range(0, 39) == 0), 1'b1);
            for (int k = 0; k < gap; k++) cyc(($urandom_range(0, 39) == 0), 1'b0);
        end
        run(1'b0, 20);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge sysclk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
